alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one combinational 32-bit ALU between two requesters (port 0, port 1) with valid/ready handshakes on request and response.
- Round-robin arbitration on ties.
- Registers the winning operands, drives them to the ALU for one execute cycle, captures result/overflow and holds the response until the owner accepts it.
- Sits between pipeline issue logic and the ALU instance.

Parameters:
DATA_W, 32, operand/result width; must match the ALU.
CNT_W, 16, width of completed-operation counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
req0_valid / req1_valid  in  1  request present
req0_ready / req1_ready  out  1  request accepted this cycle
req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands
req0_op / req1_op  in  4  ALU opcode (0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 sra, 7 gt, 8 lt)
req0_mode / req1_mode  in  1  1=signed, 0=unsigned
req0_shamt / req1_shamt  in  5  shift amount
rsp0_valid / rsp1_valid  out  1  response present
rsp0_ready / rsp1_ready  in  1  requester accepts response
rsp_result  out  DATA_W  captured result, shared by both response ports
rsp_ovf  out  1  captured overflow (ALU overflow bit 0)
alu_a, alu_b  out  DATA_W  to ALU A, B
alu_op  out  4  to ALU OpCode
alu_mode  out  2  to ALU Mode ({1'b0, mode})
alu_shamt  out  5  to ALU Shift_amt
alu_result  in  DATA_W  from ALU Result
alu_overflow  in  2  from ALU Overflow
busy  out  1  state != IDLE
ops_done  out  CNT_W  completed responses, saturating

Behaviour:
- FSM states:
  - IDLE: may accept a request.
  - EXEC: operand registers drive the ALU.
  - RESP: response held.
- Grant, combinational, in IDLE only:
  - Only one valid: grant it.
  - Both valid: grant the port other than last_grant.
- reqN_ready = (state==IDLE) && grantN. Never both ready. Ready is 0 in EXEC/RESP.
- Accept at edge T (valid&&ready):
  - Latch a, b, op, mode, shamt into the alu_* registers.
  - owner <= N; last_grant <= N; state -> EXEC.
- EXEC (one cycle): at its closing edge, rsp_result <= alu_result, rsp_ovf <= alu_overflow[0]; state -> RESP.
- RESP:
  - rspN_valid = (state==RESP) && owner==N.
  - rsp_result and rsp_ovf are stable while valid.
  - On rspN_ready: state -> IDLE; ops_done += 1, saturating at all-ones.
  - rsp_ready of the non-owner is ignored.
- Latency and throughput:
  - rsp valid visible in the cycle after EXEC, i.e. 2 edges after acceptance.
  - Minimum 3 cycles per op; no new accept in the cycle of the response handshake.
- alu_* outputs are registered and hold their last values outside EXEC. No combinational path from req inputs to alu_*.
- Requesters hold fields stable while valid && !ready. The block samples only at the handshake.
- Reset (any state, asynchronous):
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - owner=0; alu_a/alu_b/alu_op/alu_mode/alu_shamt=0; rsp_result=0, rsp_ovf=0; ops_done=0.
  - Outputs: all ready/valid=0, busy=0.
  - An in-flight operation is dropped with no response.
- Request valid held across RESP: that port re-arbitrates in IDLE; the other port wins if it is also valid.

Optional Feature:
ALU_SHARE_OPCHECK_EN:
- Defined: opcodes 9..15 are accepted but skip EXEC. Go directly to RESP with rsp_result=0, rsp_ovf=0, and assert an extra output rsp_err=1 for that response (0 otherwise, 0 on reset). ALU registers are not updated for that op.
- Undefined: no rsp_err port; all opcodes pass to the ALU (which returns 0 for 9..15) with normal timing.

Test Plan:
- Reset, req0 add a=50 b=60 mode=0, rsp0_ready=1 -> req0_ready at T, rsp0_valid at T+2, rsp_result=110, rsp_ovf=0, ops_done=1.
- Both valid continuously, rsp ready=1 -> grants alternate 0,1,0,1; each response goes to the correct port; req1 waits exactly one transaction.
- req1 unsigned add a=0xFFFFFFFF b=1, rsp1_ready low 5 cycles -> rsp1_valid held, rsp_result=0, rsp_ovf=1 stable; req0_ready stays 0 until handshake.
- Signed lt a=-800 b=6 -> rsp_result=1; sra a=0x80000000 shamt=4 -> rsp_result=0xF8000000.
- Assert rst during EXEC -> all outputs 0 immediately, no rsp valid, ops_done=0; next request completes normally.
- With ALU_SHARE_OPCHECK_EN, op=4'hC -> rsp_valid 1 edge after accept, rsp_err=1, rsp_result=0, alu_* unchanged.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two valid/ready requesters (optional ALU_SHARE_OPCHECK_EN)
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  input  logic              req0_mode,
  input  logic [4:0]        req0_shamt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  input  logic              req1_mode,
  input  logic [4:0]        req1_shamt,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_ovf,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic [1:0]        alu_mode,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [1:0]        alu_overflow,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
`ifdef ALU_SHARE_OPCHECK_EN
  ,
  output logic              rsp_err
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, owner, acc, take, bad;
  logic unused;
  assign unused = alu_overflow[1];
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // grant, handshakes and next state
  always_comb begin
    req0_ready = state == IDLE && req0_valid && (!req1_valid || last_grant);
    req1_ready = state == IDLE && req1_valid && (!req0_valid || !last_grant);
    acc = req0_ready || req1_ready;
`ifdef ALU_SHARE_OPCHECK_EN
    bad = (req1_ready ? req1_op : req0_op) > 4'd8;
`else
    bad = 1'b0;
`endif
    take = state == RESP && (owner ? rsp1_ready : rsp0_ready);
    state_nx = state == IDLE ? (acc ? (bad ? RESP : EXEC) : IDLE) :
               state == EXEC ? RESP : (take ? IDLE : RESP);
    rsp0_valid = state == RESP && !owner;
    rsp1_valid = state == RESP && owner;
    busy = state != IDLE;
  end
  // operand capture, result capture and completion count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= 1'b0;
      last_grant <= 1'b1;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      alu_mode <= '0;
      alu_shamt <= '0;
      rsp_result <= '0;
      rsp_ovf <= 1'b0;
      ops_done <= '0;
`ifdef ALU_SHARE_OPCHECK_EN
      rsp_err <= 1'b0;
`endif
    end else begin
      if (acc) begin
        owner <= req1_ready;
        last_grant <= req1_ready;
        if (!bad) begin
          alu_a <= req1_ready ? req1_a : req0_a;
          alu_b <= req1_ready ? req1_b : req0_b;
          alu_op <= req1_ready ? req1_op : req0_op;
          alu_mode <= {1'b0, req1_ready ? req1_mode : req0_mode};
          alu_shamt <= req1_ready ? req1_shamt : req0_shamt;
        end
`ifdef ALU_SHARE_OPCHECK_EN
        rsp_err <= bad;
        if (bad) begin
          rsp_result <= '0;
          rsp_ovf <= 1'b0;
        end
`endif
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_ovf <= alu_overflow[0];
      end
      if (take && ops_done != '1) ops_done <= ops_done + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized transaction-level checks of alu_share_arbiter
module tb_alu_share_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0] req0_op = 0, req1_op = 0;
  logic req0_mode = 0, req1_mode = 0;
  logic [4:0] req0_shamt = 0, req1_shamt = 0;
  logic rsp0_valid, rsp1_valid, rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic rsp_ovf, busy;
  logic [3:0] alu_op;
  logic [1:0] alu_mode, alu_overflow;
  logic [4:0] alu_shamt;
  logic [15:0] ops_done;
  logic [32:0] alu_o;
  int checks = 0, errors = 0;
  bit pend;
  int age, own, last;
  logic [15:0] done;
  logic [31:0] er, la, lb;
  logic eo, ee, lmode;
  logic [3:0] lop;
  logic [4:0] lsh;
  logic s_r0, s_r1, s_v0, s_v1, s_ovf;
  logic [31:0] s_res;
`ifdef ALU_SHARE_OPCHECK_EN
  logic rsp_err;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_mode(req0_mode), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_mode(req1_mode), .req1_shamt(req1_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_ovf(rsp_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mode(alu_mode), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .busy(busy), .ops_done(ops_done)
`ifdef ALU_SHARE_OPCHECK_EN
    , .rsp_err(rsp_err)
`endif
  );

  // behavioural ALU: returns {overflow, result}
  function automatic logic [32:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic m, logic [4:0] sh);
    logic [32:0] s;
    logic [31:0] d;
    s = {1'b0, a} + {1'b0, b};
    d = a - b;
    case (op)
      4'd0: return {m ? (a[31] == b[31] && s[31] != a[31]) : s[32], s[31:0]};
      4'd1: return {m ? (a[31] != b[31] && d[31] != a[31]) : (a < b), d};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a << sh};
      4'd5: return {1'b0, a >> sh};
      4'd6: return {1'b0, 32'($signed(a) >>> sh)};
      4'd7: return {1'b0, 31'd0, m ? $signed(a) > $signed(b) : a > b};
      4'd8: return {1'b0, 31'd0, m ? $signed(a) < $signed(b) : a < b};
      default: return 33'd0;
    endcase
  endfunction

  assign alu_o = alu_f(alu_a, alu_b, alu_op, alu_mode[0], alu_shamt);
  assign alu_result = alu_o[31:0];
  assign alu_overflow = {1'b0, alu_o[32]};

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend = 0; age = 0; own = 0; last = 1; done = 0;
    er = 0; eo = 0; ee = 0; la = 0; lb = 0; lop = 0; lmode = 0; lsh = 0;
  endtask

  // one clock: check outputs against the transaction model, then advance the model at the edge
  task automatic cycle();
    int w;
    logic [32:0] r;
    logic [3:0] op;
    #1;
    s_r0 = req0_ready; s_r1 = req1_ready; s_v0 = rsp0_valid; s_v1 = rsp1_valid;
    s_res = rsp_result; s_ovf = rsp_ovf;
    w = pend ? -1 : (req0_valid && req1_valid) ? (last == 0 ? 1 : 0) :
        req0_valid ? 0 : req1_valid ? 1 : -1;
    chk("req0_ready", req0_ready, w == 0);
    chk("req1_ready", req1_ready, w == 1);
    chk("busy", busy, pend);
    chk("rsp0_valid", rsp0_valid, pend && age >= 2 && own == 0);
    chk("rsp1_valid", rsp1_valid, pend && age >= 2 && own == 1);
    if (pend && age >= 2) begin
      chk("rsp_result", rsp_result, er);
      chk("rsp_ovf", rsp_ovf, eo);
`ifdef ALU_SHARE_OPCHECK_EN
      chk("rsp_err", rsp_err, ee);
`endif
    end
    chk("ops_done", ops_done, done);
    chk("alu_a", alu_a, la);
    chk("alu_b", alu_b, lb);
    chk("alu_ctl", {alu_op, alu_mode, alu_shamt}, {lop, 1'b0, lmode, lsh});
    @(posedge clk);
    if (pend) begin
      if (age >= 2 && (own == 1 ? rsp1_ready : rsp0_ready)) begin
        pend = 0;
        if (done != 16'hFFFF) done++;
      end else age++;
    end else if (w >= 0) begin
      op = w == 1 ? req1_op : req0_op;
      pend = 1; own = w; last = w; age = 1; ee = 0;
`ifdef ALU_SHARE_OPCHECK_EN
      if (op > 8) begin
        age = 2; ee = 1; er = 0; eo = 0;
      end
`endif
      if (!ee) begin
        la = w == 1 ? req1_a : req0_a;
        lb = w == 1 ? req1_b : req0_b;
        lop = op;
        lmode = w == 1 ? req1_mode : req0_mode;
        lsh = w == 1 ? req1_shamt : req0_shamt;
        r = alu_f(la, lb, lop, lmode, lsh);
        er = r[31:0]; eo = r[32];
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(int p, logic v, logic [31:0] a, logic [31:0] b, logic [3:0] op, logic m, logic [4:0] sh);
    if (p == 1) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_mode = m; req1_shamt = sh;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_mode = m; req0_shamt = sh;
    end
  endtask

  task automatic do_op(int p, logic [31:0] a, logic [31:0] b, logic [3:0] op, logic m, logic [4:0] sh,
                       int lat, int hold, output logic [31:0] r, output logic o);
    int n;
    bit got;
    drive(p, 1, a, b, op, m, sh);
    rsp0_ready = 0; rsp1_ready = 0;
    got = 0;
    for (n = 0; n < 10 && !got; n++) begin
      cycle();
      got = p == 1 ? s_r1 : s_r0;
    end
    chk("accept_seen", got, 1);
    if (p == 1) req1_valid = 0; else req0_valid = 0;
    got = 0;
    for (n = 1; n <= 10; n++) begin
      cycle();
      got = p == 1 ? s_v1 : s_v0;
      if (got) break;
    end
    chk("rsp_seen", got, 1);
    chk("rsp_latency", n, lat);
    r = s_res; o = s_ovf;
    repeat (hold) cycle();
    if (p == 1) rsp1_ready = 1; else rsp0_ready = 1;
    cycle();
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r;
    logic o;
    bit h0, h1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_ops", ops_done, 0);
    chk("rst_result", {rsp_ovf, rsp_result}, 0);
    rst = 0;
    @(negedge clk);
    do_op(0, 50, 60, 4'd0, 0, 0, 2, 0, r, o);
    chk("add_result", r, 110);
    chk("add_ovf", o, 0);
    #1 chk("ops_after_add", ops_done, 1);
    drive(0, 1, 1, 1, 4'd0, 0, 0);
    do_op(1, 32'hFFFF_FFFF, 1, 4'd0, 0, 0, 2, 5, r, o);
    chk("wrap_result", r, 0);
    chk("wrap_ovf", o, 1);
    rsp0_ready = 1; rsp1_ready = 1;
    drive(0, 1, 7, 3, 4'd1, 1, 0);
    drive(1, 1, 9, 4, 4'd3, 0, 0);
    repeat (16) cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle();
    do_op(0, -32'sd800, 6, 4'd8, 1, 0, 2, 0, r, o);
    chk("slt_result", r, 1);
    do_op(1, 32'h8000_0000, 0, 4'd6, 1, 5'd4, 2, 1, r, o);
    chk("sra_result", r, 32'hF800_0000);
`ifdef ALU_SHARE_OPCHECK_EN
    do_op(0, 5, 6, 4'hC, 0, 0, 1, 0, r, o);
    chk("badop_result", {o, r}, 0);
`endif
    drive(0, 1, 123, 456, 4'd0, 0, 0);
    cycle();
    chk("pre_rst_accept", s_r0, 1);
    req0_valid = 0;
    rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("arst_ops", ops_done, 0);
    chk("arst_alu", {alu_a, alu_b}, 0);
    model_reset();
    #1 rst = 0;
    @(negedge clk);
    repeat (3) cycle();
    do_op(0, 50, 60, 4'd0, 0, 0, 2, 0, r, o);
    chk("post_rst_result", r, 110);
    for (int i = 0; i < 3000; i++) begin
      h0 = req0_valid && !s_r0;
      h1 = req1_valid && !s_r1;
      if (!h0) drive(0, $urandom_range(0, 9) < 6, rnd(), rnd(), 4'($urandom_range(0, 15)), 1'($urandom), 5'($urandom));
      if (!h1) drive(1, $urandom_range(0, 9) < 6, rnd(), rnd(), 4'($urandom_range(0, 15)), 1'($urandom), 5'($urandom));
      rsp0_ready = 1'($urandom);
      rsp1_ready = 1'($urandom);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
